float_adder: RTL

Sequential floating-point adder/subtractor that directly consumes `float_multiplier` products (15-bit signed mantissa, 5-bit signed exponent) in the FFT butterfly datapath. It takes two operands through a valid/ready handshake and aligns exponents one bit per cycle. It then adds and renormalizes one bit per cycle, and holds the result until the downstream stage accepts it. Value convention: V = M × 2^E, with M two's complement and E two's complement.

---
 rtl/float_adder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/float_adder.sv
// Sequential floating-point adder/subtractor (V = M * 2^E, two's complement M and E).
// Aligns exponents and renormalizes one bit per cycle; result held until accepted.
module float_adder #(
  parameter int MW = 15,
  parameter int EW = 5
) (
  input  logic          clkExt,
  input  logic          iRst,
  input  logic          iValid,
  output logic          oReady,
  input  logic [MW-1:0] iMantA,
  input  logic [MW-1:0] iMantB,
  input  logic [EW-1:0] iExpA,
  input  logic [EW-1:0] iExpB,
  input  logic          iSub,
  output logic          oValid,
  input  logic          iReady,
  output logic [MW-1:0] oMantR,
  output logic [EW-1:0] oExpR,
  output logic          oOvf
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [EW-1:0]        EMIN    = {1'b1, {(EW-1){1'b0}}};
  localparam logic [EW-1:0]        EMAX    = {1'b0, {(EW-1){1'b1}}};
  localparam logic signed [EW:0]   DLIM    = (EW+1)'(MW);
  localparam logic signed [MW:0]   SAT_POS = {2'b00, {(MW-1){1'b1}}};
  localparam logic signed [MW:0]   SAT_NEG = {2'b11, {(MW-1){1'b0}}};

  state_t                state_reg, state_next;
  logic signed [MW:0]    a_reg, a_next, b_reg, b_next, s_reg, s_next;
  logic [EW-1:0]         ea_reg, ea_next, eb_reg, eb_next, e_reg, e_next;
  logic                  ovf_reg, ovf_next;
  logic signed [MW:0]    b_ext;
  logic signed [EW:0]    d;

  // Difference taken one bit wider so that e.g. 15 - (-16) does not wrap.
  assign d     = $signed({ea_reg[EW-1], ea_reg}) - $signed({eb_reg[EW-1], eb_reg});
  assign b_ext = $signed({iMantB[MW-1], iMantB});

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    ea_next    = ea_reg;
    eb_next    = eb_reg;
    s_next     = s_reg;
    e_next     = e_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (iValid) begin
          a_next     = $signed({iMantA[MW-1], iMantA});
          b_next     = iSub ? -b_ext : b_ext;
          ea_next    = iExpA;
          eb_next    = iExpB;
          ovf_next   = 1'b0;
          state_next = ALIGN;
        end
      end
      ALIGN: begin
        if (d == '0) begin
          state_next = ADD;
        end else if (d > DLIM) begin
          b_next     = '0;
          eb_next    = ea_reg;
          state_next = ADD;
        end else if (d < -DLIM) begin
          a_next     = '0;
          ea_next    = eb_reg;
          state_next = ADD;
        end else if (d > 0) begin
          b_next  = b_reg >>> 1;
          eb_next = eb_reg + EW'(1);
        end else begin
          a_next  = a_reg >>> 1;
          ea_next = ea_reg + EW'(1);
        end
      end
      ADD: begin
        s_next     = a_reg + b_reg;
        e_next     = ea_reg;
        state_next = NORM;
      end
      NORM: begin
        if (s_reg == '0) begin
          e_next     = EMIN;
          state_next = DONE;
        end else if (s_reg[MW] != s_reg[MW-1]) begin
          // Carry reached the guard bit: shift right, or saturate at the top exponent.
          if (e_reg == EMAX) begin
            s_next     = s_reg[MW] ? SAT_NEG : SAT_POS;
            ovf_next   = 1'b1;
            state_next = DONE;
          end else begin
            s_next = s_reg >>> 1;
            e_next = e_reg + EW'(1);
          end
        end else if (s_reg[MW-1] == s_reg[MW-2] && e_reg != EMIN) begin
          s_next = s_reg <<< 1;
          e_next = e_reg - EW'(1);
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (iReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkExt) begin
    if (iRst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      ea_reg    <= '0;
      eb_reg    <= '0;
      s_reg     <= '0;
      e_reg     <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      ea_reg    <= ea_next;
      eb_reg    <= eb_next;
      s_reg     <= s_next;
      e_reg     <= e_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign oReady = (state_reg == IDLE);
  assign oValid = (state_reg == DONE);
  assign oMantR = s_reg[MW-1:0];
  assign oExpR  = e_reg;
  assign oOvf   = ovf_reg;

endmodule
